// File: rtl/warbler_bit_packer.sv
// warbler_bit_packer: drops a warm-up prefix of the NLFSR3 keystream, packs the
// remaining bits MSB-first into WORD_W-bit words and buffers them in a 2-entry FIFO.
module warbler_bit_packer #(
    parameter int WORD_W  = 32,
    parameter int DISCARD = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              bit_in,
    input  logic              bit_vld,
    output logic              bit_rdy,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf,
    output logic              busy
);

    localparam int BCW = $clog2(WORD_W);
    localparam int DCW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);
    localparam logic [DCW-1:0] DISC_LAST = DCW'((DISCARD > 0) ? DISCARD - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISCARD,
        ST_COLLECT
    } state_e;

    state_e            state_q, state_d;
    logic [DCW-1:0]    disc_cnt_q, disc_cnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0] sreg_q, sreg_d;
    logic              ovf_q, ovf_d;
    logic              busy_q;
    logic [WORD_W-1:0] fifo_mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;

    logic [WORD_W-1:0] shifted;
    logic              word_done;
    logic              accept;
    logic              push;
    logic              pop;

    // The word's MSB only ever lives in the pushed value, so sreg holds WORD_W-1 bits.
    assign shifted   = {sreg_q, bit_in};
    assign word_done = (state_q == ST_COLLECT) && (bit_cnt_q == BIT_LAST);
    assign bit_rdy   = !(word_done && (fifo_cnt_q == 2'd2));
    assign accept    = bit_vld && bit_rdy && !start && !stop && (state_q != ST_IDLE);
    assign push      = accept && word_done;
    assign pop       = out_valid && out_ready && !start;

    assign out_valid = (fifo_cnt_q != 2'd0);
    assign out_data  = fifo_mem_q[rd_ptr_q];
    assign ovf       = ovf_q;
    assign busy      = busy_q;

    // NOTE: every _d gets its hold value first so no path through the branches infers a latch.
    always_comb begin
        state_d    = state_q;
        disc_cnt_d = disc_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sreg_d     = sreg_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        if (start) begin
            state_d    = (DISCARD == 0) ? ST_COLLECT : ST_DISCARD;
            disc_cnt_d = '0;
            bit_cnt_d  = '0;
            sreg_d     = '0;
            ovf_d      = 1'b0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
        end else begin
            if (bit_vld && !bit_rdy) begin
                ovf_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase

            // A stop abandons the partial word but leaves finished words to drain.
            if (stop) begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                sreg_d    = '0;
            end else if (accept) begin
                if (state_q == ST_DISCARD) begin
                    disc_cnt_d = disc_cnt_q + DCW'(1);
                    if (disc_cnt_q == DISC_LAST) begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    sreg_d    = shifted[WORD_W-2:0];
                    bit_cnt_d = word_done ? '0 : bit_cnt_q + BCW'(1);
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            disc_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            sreg_q        <= '0;
            ovf_q         <= 1'b0;
            busy_q        <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            // NOTE: the two FIFO slots are reset because out_data must read zero straight out of reset.
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            disc_cnt_q <= disc_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sreg_q     <= sreg_d;
            ovf_q      <= ovf_d;
            busy_q     <= (state_d != ST_IDLE);
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_warbler_bit_packer.sv
// Bench for warbler_bit_packer: two instances (DISCARD=4 and DISCARD=0) share one
// stimulus stream; an arithmetic model feeds a scoreboard checked by a monitor.
module tb_warbler_bit_packer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         bit_in;
    logic         bit_vld;
    logic         out_ready;
    logic         rdy_o   [2];
    logic [W-1:0] data_o  [2];
    logic         valid_o [2];
    logic         ovf_o   [2];
    logic         busy_o  [2];

    warbler_bit_packer #(.WORD_W(W), .DISCARD(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .bit_in(bit_in), .bit_vld(bit_vld), .bit_rdy(rdy_o[0]),
        .out_data(data_o[0]), .out_valid(valid_o[0]), .out_ready(out_ready),
        .ovf(ovf_o[0]), .busy(busy_o[0])
    );

    warbler_bit_packer #(.WORD_W(W), .DISCARD(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .bit_in(bit_in), .bit_vld(bit_vld), .bit_rdy(rdy_o[1]),
        .out_data(data_o[1]), .out_valid(valid_o[1]), .out_ready(out_ready),
        .ovf(ovf_o[1]), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: run flag, bits still to skip, partial word, words held.
    bit          m_active [2];
    int          m_skip   [2];
    int          m_nbits  [2];
    int unsigned m_word   [2];
    int          m_occ    [2];
    bit          m_ovf    [2];
    logic [W-1:0] sb0 [$];
    logic [W-1:0] sb1 [$];

    bit           e_rdy   [2];
    bit           e_valid [2];
    bit           e_ovf   [2];
    bit           e_busy  [2];
    bit           cyc_start;
    bit           mon_en;
    logic [W-1:0] last_pop [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int disc_of(input int u);
        return (u == 0) ? 4 : 0;
    endfunction

    function automatic bit model_rdy(input int u);
        return !(m_active[u] && m_skip[u] == 0 && m_nbits[u] == W - 1 && m_occ[u] == 2);
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_active[u] = 1'b0;
            m_skip[u]   = 0;
            m_nbits[u]  = 0;
            m_word[u]   = 0;
            m_occ[u]    = 0;
            m_ovf[u]    = 1'b0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    task automatic model_step(input int u, input bit s, input bit p, input bit v,
                              input bit b, input bit r);
        bit rdy;
        rdy        = model_rdy(u);
        e_rdy[u]   = rdy;
        e_valid[u] = (m_occ[u] > 0);
        e_ovf[u]   = m_ovf[u];
        e_busy[u]  = m_active[u];
        if (s) begin
            m_active[u] = 1'b1;
            m_skip[u]   = disc_of(u);
            m_nbits[u]  = 0;
            m_word[u]   = 0;
            m_occ[u]    = 0;
            m_ovf[u]    = 1'b0;
            if (u == 0) sb0.delete();
            else        sb1.delete();
        end else begin
            if (v && !rdy) m_ovf[u] = 1'b1;
            if (m_occ[u] > 0 && r) m_occ[u]--;
            if (p) begin
                m_active[u] = 1'b0;
                m_nbits[u]  = 0;
                m_word[u]   = 0;
            end else if (m_active[u] && v && rdy) begin
                if (m_skip[u] > 0) begin
                    m_skip[u]--;
                end else begin
                    m_word[u] = (m_word[u] * 2 + b) % (1 << W);
                    m_nbits[u]++;
                    if (m_nbits[u] == W) begin
                        if (u == 0) sb0.push_back(m_word[u][W-1:0]);
                        else        sb1.push_back(m_word[u][W-1:0]);
                        m_occ[u]++;
                        m_nbits[u] = 0;
                        m_word[u]  = 0;
                    end
                end
            end
        end
    endtask

    // One clock cycle of stimulus, driven at the falling edge.
    task automatic cyc(input bit s, input bit p, input bit v, input bit b, input bit r);
        @(negedge clk);
        start     = s;
        stop      = p;
        bit_vld   = v;
        bit_in    = b;
        out_ready = r;
        cyc_start = s;
        model_step(0, s, p, v, b, r);
        model_step(1, s, p, v, b, r);
    endtask

    task automatic mon_check(input int u);
        logic [W-1:0] exp_word;
        bit           have;
        check($sformatf("bit_rdy%0d", u), 32'(rdy_o[u]), 32'(e_rdy[u]));
        check($sformatf("out_valid%0d", u), 32'(valid_o[u]), 32'(e_valid[u]));
        check($sformatf("ovf%0d", u), 32'(ovf_o[u]), 32'(e_ovf[u]));
        check($sformatf("busy%0d", u), 32'(busy_o[u]), 32'(e_busy[u]));
        if (!cyc_start && valid_o[u]) begin
            have = (u == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL out_data%0d actual=%0h expected=no word outstanding at %0t",
                         u, data_o[u], $time);
            end else begin
                exp_word = (u == 0) ? sb0[0] : sb1[0];
                check($sformatf("out_data%0d", u), 32'(data_o[u]), 32'(exp_word));
                if (out_ready) begin
                    last_pop[u] = data_o[u];
                    if (u == 0) void'(sb0.pop_front());
                    else        void'(sb1.pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                mon_check(0);
                mon_check(1);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s_bit_rdy%0d", tag, u), 32'(rdy_o[u]), 32'd1);
            check($sformatf("%s_out_data%0d", tag, u), 32'(data_o[u]), 32'd0);
            check($sformatf("%s_out_valid%0d", tag, u), 32'(valid_o[u]), 32'd0);
            check($sformatf("%s_ovf%0d", tag, u), 32'(ovf_o[u]), 32'd0);
            check($sformatf("%s_busy%0d", tag, u), 32'(busy_o[u]), 32'd0);
        end
    endtask

    initial begin
        logic [11:0] pat;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        bit_in    = 1'b0;
        bit_vld   = 1'b0;
        out_ready = 1'b0;
        mon_en    = 1'b0;
        cyc_start = 1'b0;
        last_pop[0] = '0;
        last_pop[1] = '0;
        model_reset();

        #12;
        check_reset_values("reset");
        @(negedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Warm-up discard of 4, then 0xA5 packed MSB-first.
        pat = 12'b1111_1010_0101;
        cyc(1, 0, 0, 0, 1);
        for (int i = 11; i >= 0; i--) cyc(0, 0, 1, pat[i], 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        check("tp1_word", 32'(last_pop[0]), 32'h0000_00A5);
        check("tp1_ovf", 32'(ovf_o[0]), 32'd0);
        cyc(0, 1, 0, 0, 1);

        // No warm-up: eight ones give 0xFF right after the eighth bit.
        cyc(1, 0, 0, 0, 1);
        repeat (8) cyc(0, 0, 1, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        check("tp2_word", 32'(last_pop[1]), 32'h0000_00FF);
        cyc(0, 1, 0, 0, 1);

        // Consumer stalled: FIFO fills, 24th bit overflows the DISCARD=0 packer.
        cyc(1, 0, 0, 0, 0);
        repeat (24) cyc(0, 0, 1, 1'($urandom_range(1)), 0);
        cyc(0, 0, 1, 1'($urandom_range(1)), 1);
        check("tp3_ovf", 32'(ovf_o[1]), 32'd1);
        check("tp3_valid", 32'(valid_o[1]), 32'd1);
        cyc(0, 0, 1, 1'($urandom_range(1)), 0);
        repeat (6) cyc(0, 0, 0, 0, 1);

        // Stop mid-word: the finished word still drains, later bits are ignored.
        cyc(1, 0, 0, 0, 0);
        repeat (13) cyc(0, 0, 1, 1'($urandom_range(1)), 0);
        cyc(0, 1, 0, 0, 0);
        repeat (4) cyc(0, 0, 1, 1'($urandom_range(1)), 0);
        check("tp5_busy", 32'(busy_o[1]), 32'd0);
        check("tp5_held", 32'(valid_o[1]), 32'd1);
        repeat (3) cyc(0, 0, 1, 1'($urandom_range(1)), 1);
        check("tp5_drained", 32'(valid_o[1]), 32'd0);

        // A start with words queued and ovf set flushes everything.
        cyc(1, 0, 0, 0, 0);
        repeat (26) cyc(0, 0, 1, 1'($urandom_range(1)), 0);
        cyc(1, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0);
        check("flush_valid0", 32'(valid_o[0]), 32'd0);
        check("flush_valid1", 32'(valid_o[1]), 32'd0);
        check("flush_ovf1", 32'(ovf_o[1]), 32'd0);

        // Random traffic with occasional start/stop and back-pressure bursts.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(99) == 0), 1'($urandom_range(99) == 0),
                1'($urandom_range(9) < 7), 1'($urandom_range(1)),
                1'($urandom_range(9) < ((i / 200) % 2 == 0 ? 6 : 2)));
        end

        // Asynchronous reset mid-COLLECT with a word waiting.
        cyc(1, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 1, 1'($urandom_range(1)), 0);
        #2;
        mon_en    = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        bit_vld   = 1'b0;
        out_ready = 1'b0;
        check("pre_rst_valid1", 32'(valid_o[1]), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (4) cyc(0, 0, 1, 1'($urandom_range(1)), 1);
        check("post_rst_busy0", 32'(busy_o[0]), 32'd0);
        repeat (2) cyc(0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/warbler_bit_packer.md
# warbler_bit_packer

Downstream consumer of the NLFSR3 keystream stage: samples the serial `o_warbler` bit on every cycle the NLFSR is clocked, discards a programmable warm-up prefix, and packs the surviving bits into WORD_W-bit words. Completed words go into a 2-entry output FIFO drained by a valid/ready interface to the TRNG post-processing / bus side. `bit_rdy` back-pressures the NLFSR clock-enable logic so that no word is lost unless the controller ignores it.

## Interface
- WORD_W, 32, packed word width (≥2)
- DISCARD, 64, bits dropped after each `start` before packing begins (0 allowed)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  sync pulse: flush FIFO and partial word, clear discard counter, begin run
- stop  in  1  sync pulse: end run, drop partial word, keep FIFO contents
- bit_in  in  1  keystream bit (NLFSR3 `o_warbler`)
- bit_vld  in  1  bit_in valid this cycle (driven with `nlfsr3_ce`)
- bit_rdy  out  1  packer can accept bit_in this cycle
- out_data  out  WORD_W  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head word
- ovf  out  1  sticky: a bit was presented while bit_rdy=0; cleared only by start or rst
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, DISCARD, COLLECT. Reset → IDLE.
- IDLE: bit_vld ignored, no ovf. start → DISCARD (→ COLLECT directly if DISCARD=0).
- DISCARD: each accepted bit increments disc_cnt; the DISCARD-th accepted bit → COLLECT; that bit is not packed.
- COLLECT: accepted bit shifted in: `sreg <= {sreg[WORD_W-2:0], bit_in}`; first packed bit of a word ends at MSB. bit_cnt counts 0..WORD_W-1; the WORD_W-th bit pushes `{sreg[WORD_W-2:0], bit_in}` into FIFO, bit_cnt wraps to 0.
- Accept = bit_vld & bit_rdy. bit_rdy = !(state==COLLECT & bit_cnt==WORD_W-1 & fifo_cnt==2); uses registered fifo_cnt, so a same-cycle pop does not raise it.
- bit_vld & !bit_rdy: bit dropped, counters unchanged, ovf ← 1.
- FIFO: 2 entries, pop when out_valid & out_ready. Push and pop in the same cycle are both honoured at any occupancy allowed by bit_rdy.
- start (any state): FIFO emptied, sreg/bit_cnt/disc_cnt ← 0, ovf ← 0, bit_vld that cycle ignored, out_ready that cycle ignored.
- stop (any state): → IDLE, sreg/bit_cnt ← 0, FIFO untouched. start and stop together: start wins.
- Counters sized $clog2(WORD_W) and $clog2(DISCARD+1); no wrap beyond defined ranges.

## Timing
- Reset values: bit_rdy 1, out_data 0, out_valid 0, ovf 0, busy 0; all internal state 0.
- start at edge N: busy=1 after N; first bit may be accepted in cycle N+1.
- Latency: WORD_W-th bit accepted at edge N → out_valid=1, out_data=word after N (when the FIFO was empty).
- out_data stable while out_valid & !out_ready.
- ovf asserted from the edge after the dropped bit.
- Throughput: 1 bit/cycle sustained when out_ready=1 every cycle.

## Test plan
- WORD_W=8, DISCARD=4: start, then 12 bits 1,1,1,1,1,0,1,0,0,1,0,1 with out_ready=1 → one word 0xA5, out_valid for 1 cycle, ovf=0.
- DISCARD=0, WORD_W=8: 8 bits of 0xFF accepted starting the cycle after start → out_data=0xFF one cycle after the 8th bit.
- out_ready=0, stream 24 bits → two words held. bit_rdy=0 at bit 24 and the bit is dropped, ovf=1. The head word stays unchanged; the third word never appears.
- FIFO full with bit_cnt=WORD_W-1, out_ready=1 and bit_vld in the same cycle → bit dropped (registered count). The next cycle the bit is accepted and the word is pushed.
- stop mid-word after 5 packed bits with 1 word in FIFO → busy=0, the word is still drained, bit_vld is then ignored. A following start flushes the FIFO: out_valid=0 and ovf=0.
- rst asserted mid-COLLECT with out_valid=1 → all outputs at reset values immediately (asynchronous), IDLE after release.
